// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter: FSM states, the latched
// per-channel request record and the channel-selection helper.
package sdram_arb_pkg;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NUM_CH = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              we;
  } req_t;

  // Both pending: honour the round-robin pointer; otherwise take the only one pending.
  function automatic logic pick_ch(input logic [NUM_CH-1:0] pend, input logic rr_ptr);
    return (pend[0] && pend[1]) ? rr_ptr : pend[1];
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Bundle of the two per-slot request channels and the single SDRAM controller port.
// Channel index 0 is slot B, index 1 is slot A.
interface sdram_port_arbiter_if;
  import sdram_arb_pkg::*;

  logic [ADDR_W-1:0] ch_addr  [NUM_CH];
  logic [DATA_W-1:0] ch_din   [NUM_CH];
  logic              ch_we    [NUM_CH];
  logic              ch_rd    [NUM_CH];
  logic [DATA_W-1:0] ch_dout  [NUM_CH];
  logic              ch_ready [NUM_CH];

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we;
  logic              mem_req;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_ack;

  // Requesters plus controller, seen from outside the arbiter.
  modport master (
    output ch_addr, ch_din, ch_we, ch_rd, mem_dout, mem_ack,
    input  ch_dout, ch_ready, mem_addr, mem_din, mem_we, mem_req
  );

  modport slave (
    input  ch_addr, ch_din, ch_we, ch_rd, mem_dout, mem_ack,
    output ch_dout, ch_ready, mem_addr, mem_din, mem_we, mem_req
  );

endinterface

// File: rtl/sdram_req_latch.sv
// Per-channel request capture: edge-detects rd/we levels, holds one pending request
// and its latched address/data/direction until the arbiter reports completion.
module sdram_req_latch
  import sdram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_we,
  input  logic              i_rd,
  input  logic              i_grant,
  input  logic              i_complete,
  output logic              o_pending,
  output req_t              o_req,
  output logic              o_ready
);

  logic r_we_prev;
  logic r_rd_prev;
  logic r_pending;
  logic r_in_flight;
  req_t r_req;

  logic w_we_edge;
  logic w_rd_edge;
  logic w_capture;

  assign w_we_edge = i_we & ~r_we_prev;
  assign w_rd_edge = i_rd & ~r_rd_prev;
  // Edges arriving while a request is pending or in flight are dropped outright.
  assign w_capture = (w_we_edge | w_rd_edge) & ~r_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we_prev   <= 1'b0;
      r_rd_prev   <= 1'b0;
      r_pending   <= 1'b0;
      r_in_flight <= 1'b0;
      r_req       <= '0;
    end else begin
      r_we_prev <= i_we;
      r_rd_prev <= i_rd;

      if (i_complete) begin
        r_pending <= 1'b0;
      end else if (w_capture) begin
        r_pending <= 1'b1;
      end

      if (i_grant) begin
        r_in_flight <= 1'b1;
      end else if (i_complete) begin
        r_in_flight <= 1'b0;
      end

      if (w_capture) begin
        r_req.addr <= i_addr;
        r_req.din  <= i_din;
        r_req.we   <= w_we_edge;
      end
    end
  end

  assign o_pending = r_pending & ~r_in_flight;
  assign o_req     = r_req;
  assign o_ready   = ~r_pending;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter serialising two request channels onto one SDRAM controller port,
// one outstanding transaction at a time; returns per-channel read data and ready.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  sdram_port_arbiter_if.slave bus
);

  state_t r_state;
  state_t w_state_next;
  logic   r_sel;
  logic   w_sel_next;
  logic   r_rr_ptr;

  logic [NUM_CH-1:0] w_pending;
  logic [NUM_CH-1:0] w_ready;
  logic [NUM_CH-1:0] w_grant;
  logic [NUM_CH-1:0] w_complete;
  req_t              w_req [NUM_CH];

  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_din;
  logic              r_mem_we;
  logic              r_mem_req;
  logic [DATA_W-1:0] r_dout [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sdram_req_latch u_latch (
      .clk        (clk),
      .reset      (reset),
      .i_addr     (bus.ch_addr[g]),
      .i_din      (bus.ch_din[g]),
      .i_we       (bus.ch_we[g]),
      .i_rd       (bus.ch_rd[g]),
      .i_grant    (w_grant[g]),
      .i_complete (w_complete[g]),
      .o_pending  (w_pending[g]),
      .o_req      (w_req[g]),
      .o_ready    (w_ready[g])
    );

    assign bus.ch_dout[g]  = r_dout[g];
    assign bus.ch_ready[g] = w_ready[g];
  end

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_grant      = '0;
    w_complete   = '0;
    unique case (r_state)
      IDLE: begin
        if (|w_pending) begin
          w_sel_next          = pick_ch(w_pending, r_rr_ptr);
          w_grant[w_sel_next] = 1'b1;
          w_state_next        = ISSUE;
        end
      end
      ISSUE: w_state_next = WAIT;
      WAIT: begin
        // Acks seen in IDLE or ISSUE (e.g. stale after reset) never reach here.
        if (bus.mem_ack) begin
          w_complete[r_sel] = 1'b1;
          w_state_next      = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_sel      <= 1'b0;
      r_rr_ptr   <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_dout[i] <= '0;
      end
    end else begin
      r_state   <= w_state_next;
      r_sel     <= w_sel_next;
      r_mem_req <= |w_grant;

      // Controller-side fields are loaded once at grant and held through WAIT.
      if (|w_grant) begin
        r_mem_addr <= w_req[w_sel_next].addr;
        r_mem_din  <= w_req[w_sel_next].din;
        r_mem_we   <= w_req[w_sel_next].we;
      end

      if (|w_complete) begin
        r_rr_ptr <= ~r_sel;
        if (!w_req[r_sel].we) begin
          r_dout[r_sel] <= bus.mem_dout;
        end
      end
    end
  end

  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_din  = r_mem_din;
  assign bus.mem_we   = r_mem_we;
  assign bus.mem_req  = r_mem_req;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a transaction-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  logic clk;
  logic reset;

  sdram_port_arbiter_if bus ();

  sdram_port_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  int n_req = 0;
  logic [ADDR_W-1:0] req_log [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [ADDR_W-1:0] m_addr [2];
  logic [DATA_W-1:0] m_din  [2];
  logic              m_we   [2];
  bit                m_pend [2];
  bit                m_pr   [2];
  bit                m_pw   [2];
  logic [DATA_W-1:0] m_dout [2];
  int                m_cur = -1;   // channel in service, -1 when none
  int                m_age = 0;    // cycles since grant; 0 is the request cycle
  bit                m_rr  = 1'b0;
  logic [ADDR_W-1:0] m_maddr = '0;
  logic [DATA_W-1:0] m_mdin  = '0;
  logic              m_mwe   = 1'b0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = '0; m_din[i] = '0; m_we[i] = 1'b0; m_pend[i] = 1'b0;
      m_pr[i] = 1'b0; m_pw[i] = 1'b0; m_dout[i] = '0;
    end
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < 2; i++) begin
          m_pend[i] = 1'b0; m_pr[i] = 1'b0; m_pw[i] = 1'b0; m_dout[i] = '0;
        end
        m_cur = -1; m_age = 0; m_rr = 1'b0;
        m_maddr = '0; m_mdin = '0; m_mwe = 1'b0;
      end else begin
        bit old_pend [2];
        old_pend = m_pend;
        if (m_cur >= 0) begin
          if (m_age >= 1 && bus.mem_ack) begin
            if (!m_we[m_cur]) m_dout[m_cur] = bus.mem_dout;
            m_pend[m_cur] = 1'b0;
            m_rr  = (m_cur == 0);
            m_cur = -1;
          end else begin
            m_age++;
          end
        end else if (old_pend[0] || old_pend[1]) begin
          if (old_pend[0] && old_pend[1]) m_cur = m_rr ? 1 : 0;
          else                            m_cur = old_pend[0] ? 0 : 1;
          m_age   = 0;
          m_maddr = m_addr[m_cur];
          m_mdin  = m_din[m_cur];
          m_mwe   = m_we[m_cur];
        end
        for (int i = 0; i < 2; i++) begin
          bit rise_w, rise_r;
          rise_w = bus.ch_we[i] && !m_pw[i];
          rise_r = bus.ch_rd[i] && !m_pr[i];
          if ((rise_w || rise_r) && !old_pend[i]) begin
            m_pend[i] = 1'b1;
            m_addr[i] = bus.ch_addr[i];
            m_din[i]  = bus.ch_din[i];
            m_we[i]   = rise_w;
          end
          m_pw[i] = bus.ch_we[i];
          m_pr[i] = bus.ch_rd[i];
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        n_req++;
        req_log.push_back(bus.mem_addr);
      end
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("cyc ch_ready[%0d]", i), 32'(bus.ch_ready[i]), 32'(!m_pend[i]));
        chk($sformatf("cyc ch_dout[%0d]", i), 32'(bus.ch_dout[i]), 32'(m_dout[i]));
      end
      chk("cyc mem_req", 32'(bus.mem_req), 32'(m_cur >= 0 && m_age == 0));
      chk("cyc mem_addr", 32'(bus.mem_addr), 32'(m_maddr));
      chk("cyc mem_din", 32'(bus.mem_din), 32'(m_mdin));
      chk("cyc mem_we", 32'(bus.mem_we), 32'(m_mwe));
    end
  end

  // ---------------- controller stand-in: ack ctl_delay cycles after mem_req -----------
  int ctl_delay = 4;
  int ctl_cnt   = 0;
  initial begin
    bus.mem_ack  = 1'b0;
    bus.mem_dout = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (ctl_cnt == 1) begin
        bus.mem_ack = 1'b1;
        ctl_cnt = 0;
      end else if (ctl_cnt > 1) begin
        ctl_cnt--;
      end
      if (bus.mem_req) begin
        ctl_cnt      = ctl_delay;
        bus.mem_dout = bus.mem_addr[7:0] ^ 8'h91;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_rd(input int ch);
    bus.ch_rd[ch] = 1'b1;
    step();
    bus.ch_rd[ch] = 1'b0;
  endtask

  task automatic wait_req();
    int k = 0;
    while (!bus.mem_req && k < 40) begin
      step();
      k++;
    end
    if (!bus.mem_req) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_req: no mem_req within 40 cycles at %0t", $time);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(bus.ch_ready[0] && bus.ch_ready[1]) && k < 80) begin
      step();
      k++;
    end
    if (!(bus.ch_ready[0] && bus.ch_ready[1])) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: channels still busy after 80 cycles at %0t", $time);
    end
    step();
    step();
  endtask

  int q0;
  int n0;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.ch_addr[i] = '0; bus.ch_din[i] = '0; bus.ch_we[i] = 1'b0; bus.ch_rd[i] = 1'b0;
    end
    repeat (3) step();
    chk("reset ch_ready[0]", 32'(bus.ch_ready[0]), 32'd1);
    chk("reset ch_ready[1]", 32'(bus.ch_ready[1]), 32'd1);
    chk("reset mem_req", 32'(bus.mem_req), 32'd0);
    chk("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("reset ch_dout[1]", 32'(bus.ch_dout[1]), 32'd0);
    reset = 1'b0;
    step();

    // Single read on channel 1, ack four cycles after the request.
    ctl_delay = 4;
    n0 = n_req;
    bus.ch_addr[1] = 25'h0201234;
    pulse_rd(1);
    chk("rd1 ready low", 32'(bus.ch_ready[1]), 32'd0);
    wait_req();
    chk("rd1 mem_addr", 32'(bus.mem_addr), 32'h0201234);
    chk("rd1 mem_we", 32'(bus.mem_we), 32'd0);
    repeat (4) step();
    chk("rd1 ready low in ack cycle", 32'(bus.ch_ready[1]), 32'd0);
    step();
    chk("rd1 ready after ack", 32'(bus.ch_ready[1]), 32'd1);
    chk("rd1 ch_dout", 32'(bus.ch_dout[1]), 32'hA5);
    wait_idle();
    chk("rd1 one request", 32'(n_req - n0), 32'd1);

    // Simultaneous reads with rr_ptr = 0: channel 0 first.
    q0 = req_log.size();
    bus.ch_addr[0] = 25'h0000100;
    bus.ch_addr[1] = 25'h1000200;
    bus.ch_rd[0] = 1'b1;
    pulse_rd(1);
    bus.ch_rd[0] = 1'b0;
    wait_idle();
    chk("sim1 count", 32'(req_log.size() - q0), 32'd2);
    if (req_log.size() >= q0 + 2) begin
      chk("sim1 first", 32'(req_log[q0]), 32'h0000100);
      chk("sim1 second", 32'(req_log[q0+1]), 32'h1000200);
    end
    chk("sim1 dout0", 32'(bus.ch_dout[0]), 32'h91);
    chk("sim1 dout1", 32'(bus.ch_dout[1]), 32'h91);

    // Write on channel 0; data held through WAIT, ch_dout[0] untouched.
    bus.ch_addr[0] = 25'h0000010;
    bus.ch_din[0]  = 8'h3C;
    bus.ch_we[0] = 1'b1;
    step();
    bus.ch_we[0] = 1'b0;
    wait_req();
    chk("wr mem_we", 32'(bus.mem_we), 32'd1);
    chk("wr mem_din", 32'(bus.mem_din), 32'h3C);
    chk("wr mem_addr", 32'(bus.mem_addr), 32'h0000010);
    step();
    step();
    chk("wr mem_din held", 32'(bus.mem_din), 32'h3C);
    chk("wr mem_we held", 32'(bus.mem_we), 32'd1);
    wait_idle();
    chk("wr dout0 unchanged", 32'(bus.ch_dout[0]), 32'h91);

    // Simultaneous reads again, pointer now favours channel 1.
    q0 = req_log.size();
    bus.ch_addr[0] = 25'h0000055;
    bus.ch_addr[1] = 25'h1000066;
    bus.ch_rd[0] = 1'b1;
    pulse_rd(1);
    bus.ch_rd[0] = 1'b0;
    wait_idle();
    if (req_log.size() >= q0 + 2) begin
      chk("sim2 first", 32'(req_log[q0]), 32'h1000066);
      chk("sim2 second", 32'(req_log[q0+1]), 32'h0000055);
    end else begin
      chk("sim2 count", 32'(req_log.size() - q0), 32'd2);
    end
    chk("sim2 dout0", 32'(bus.ch_dout[0]), 32'hC4);
    chk("sim2 dout1", 32'(bus.ch_dout[1]), 32'hF7);

    // Repeat edge on channel 0 while it is in WAIT is dropped.
    ctl_delay = 6;
    bus.ch_addr[0] = 25'h0000077;
    pulse_rd(0);
    wait_req();
    n0 = n_req;
    step();
    step();
    bus.ch_addr[0] = 25'h0000999;
    pulse_rd(0);
    wait_idle();
    repeat (4) step();
    chk("dup no second req", 32'(n_req - n0), 32'd0);
    chk("dup dout0", 32'(bus.ch_dout[0]), 32'hE6);

    // Channel 1 edge in the same cycle as the channel 0 ack.
    ctl_delay = 4;
    bus.ch_addr[0] = 25'h0000123;
    bus.ch_addr[1] = 25'h1000321;
    pulse_rd(0);
    wait_req();
    repeat (4) step();
    bus.ch_rd[1] = 1'b1;
    step();
    bus.ch_rd[1] = 1'b0;
    chk("same-cycle no req yet", 32'(bus.mem_req), 32'd0);
    chk("same-cycle ch0 ready", 32'(bus.ch_ready[0]), 32'd1);
    step();
    chk("same-cycle ch1 req", 32'(bus.mem_req), 32'd1);
    chk("same-cycle ch1 addr", 32'(bus.mem_addr), 32'h1000321);
    wait_idle();

    // Reset during WAIT; the late ack must be ignored.
    ctl_delay = 4;
    bus.ch_addr[0] = 25'h00000AB;
    pulse_rd(0);
    wait_req();
    n0 = n_req;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (6) step();
    chk("rst ch_ready[0]", 32'(bus.ch_ready[0]), 32'd1);
    chk("rst ch_ready[1]", 32'(bus.ch_ready[1]), 32'd1);
    chk("rst ch_dout[0]", 32'(bus.ch_dout[0]), 32'd0);
    chk("rst ch_dout[1]", 32'(bus.ch_dout[1]), 32'd0);
    chk("rst no further req", 32'(n_req - n0), 32'd0);
    chk("rst mem_addr", 32'(bus.mem_addr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
